// File: rtl/ctrl_pkg.sv
// Shared constants and types for the multicycle control sequencer:
// opcodes, ALU op codes, FSM state encodings, instruction classes.
package ctrl_pkg;

    localparam logic [6:0] OPC_R      = 7'h33;
    localparam logic [6:0] OPC_I      = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_SLT    = 3'b010;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_ILLEGAL
    } insn_class_t;

    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
        case (funct3)
            F3_BEQ:  return zero;
            F3_BNE:  return !zero;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Handshake between the control sequencer (master) and the yIF/yID/yEX/yDM
// datapath (slave).
interface ctrl_sequencer_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic [31:0]      ins;
    logic             zero;
    logic [XLEN-1:0]  branch;
    logic [XLEN-1:0]  jTarget;
    logic             mem_ready;

    logic [XLEN-1:0]  PCin;
    logic             RegWrite;
    logic             ALUSrc;
    logic [2:0]       op;
    logic             MemRead;
    logic             MemWrite;
    logic             Mem2Reg;
    logic             Link;
    logic [CNT_W-1:0] retired;
    logic             halted;
    logic             illegal;

    modport master (
        input  ins, zero, branch, jTarget, mem_ready,
        output PCin, RegWrite, ALUSrc, op, MemRead, MemWrite, Mem2Reg, Link,
               retired, halted, illegal
    );

    modport slave (
        output ins, zero, branch, jTarget, mem_ready,
        input  PCin, RegWrite, ALUSrc, op, MemRead, MemWrite, Mem2Reg, Link,
               retired, halted, illegal
    );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational instruction decode: classifies the latched IR and derives
// the ALU op and whether the second operand is the immediate.
module alu_op_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output logic [2:0]  op,
    output logic        imm_src,
    output insn_class_t cls
);
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       unused_ir_bits;

    assign opcode         = ir[6:0];
    assign funct3         = ir[14:12];
    assign funct7_5       = ir[30];
    assign unused_ir_bits = ^{ir[31], ir[29:15], ir[11:7]};

    // NOTE: every output is given a default before the case so no latch is inferred.
    always_comb begin
        cls = CLS_ILLEGAL;
        case (opcode)
            OPC_R:      cls = CLS_R;
            OPC_I:      cls = CLS_I;
            OPC_LOAD:   cls = CLS_LOAD;
            OPC_STORE:  cls = CLS_STORE;
            OPC_BRANCH: cls = CLS_BRANCH;
            OPC_JAL:    cls = CLS_JAL;
            default:    cls = CLS_ILLEGAL;
        endcase

        imm_src = (cls == CLS_I) || (cls == CLS_LOAD) || (cls == CLS_STORE);

        op = ALU_ADD;
        case (cls)
            CLS_R, CLS_I: begin
                case (funct3)
                    // sub exists only for register-register ops
                    F3_ADDSUB: op = (cls == CLS_R && funct7_5) ? ALU_SUB : ALU_ADD;
                    F3_AND:    op = ALU_AND;
                    F3_OR:     op = ALU_OR;
                    F3_SLT:    op = ALU_SLT;
                    default:   op = ALU_ADD;
                endcase
            end
            CLS_BRANCH: op = ALU_SUB;
            default:    op = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/ctrl_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer: owns PC and IR, drives the
// datapath strobes, resolves beq/bne/jal, counts retirements, optional halt.
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int             XLEN      = 32,
    parameter logic [XLEN-1:0] ENTRY    = XLEN'(32'h28),
    parameter int             CNT_W     = 16,
    parameter int             MAX_INSNS = 0
) (
    input  logic              clk,
    input  logic              reset,
    ctrl_sequencer_if.master  bus
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INSNS);

    logic [2:0]       state, state_nxt;
    logic [XLEN-1:0]  pc, next_pc;
    logic [31:0]      ir;
    logic [CNT_W-1:0] retired, retired_inc;
    logic             illegal;
    logic             retire, hit_max;

    logic [2:0]       dec_op;
    logic             imm_src;
    insn_class_t      cls;

    alu_op_decode u_dec (
        .ir      (ir),
        .op      (dec_op),
        .imm_src (imm_src),
        .cls     (cls)
    );

    assign retired_inc = retired + CNT_W'(1);
    assign hit_max     = (MAX_INSNS != 0) && (retired_inc == MAX_CNT);

    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        case (state)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                case (cls)
                    CLS_JAL:     state_nxt = S_WB;
                    CLS_ILLEGAL: state_nxt = S_HALT;
                    default:     state_nxt = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (cls)
                    CLS_LOAD, CLS_STORE: state_nxt = S_MEM;
                    CLS_BRANCH:          retire    = 1'b1;
                    default:             state_nxt = S_WB;
                endcase
            end
            S_MEM: begin
                if (bus.mem_ready) begin
                    if (cls == CLS_STORE) retire = 1'b1;
                    else                  state_nxt = S_WB;
                end
            end
            S_WB:    retire    = 1'b1;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_FETCH;
        endcase
        if (retire) state_nxt = hit_max ? S_HALT : S_FETCH;
    end

    // zero, branch and jTarget are only meaningful in the retiring cycle
    always_comb begin
        next_pc = pc + XLEN'(4);
        if (cls == CLS_BRANCH && branch_taken(ir[14:12], bus.zero))
            next_pc = pc + bus.branch;
        else if (cls == CLS_JAL)
            next_pc = pc + bus.jTarget;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH;
            pc      <= ENTRY;
            ir      <= '0;
            retired <= '0;
            illegal <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH) ir <= bus.ins;
            if (state == S_DECODE && cls == CLS_ILLEGAL) illegal <= 1'b1;
            if (retire) begin
                pc      <= next_pc;
                retired <= retired_inc;
            end
        end
    end

    assign bus.PCin     = pc;
    assign bus.RegWrite = (state == S_WB);
    assign bus.ALUSrc   = (state == S_EXEC || state == S_MEM) && imm_src;
    assign bus.op       = dec_op;
    assign bus.MemRead  = (state == S_MEM) && (cls == CLS_LOAD);
    assign bus.MemWrite = (state == S_MEM) && (cls == CLS_STORE);
    assign bus.Mem2Reg  = (state == S_WB) && (cls == CLS_LOAD);
    assign bus.Link     = (state == S_WB) && (cls == CLS_JAL);
    assign bus.retired  = retired;
    assign bus.halted   = (state == S_HALT);
    assign bus.illegal  = illegal;
endmodule
